// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_pkg
//  Brief    : Shared constants and types for the HUB75 framebuffer arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package hub75_pkg;

    // Per-page word address width and RGB888 pixel word width
    localparam int FB_ADDR_W    = 13;
    localparam int FB_DATA_W    = 24;

    // Default host starvation bound (cycles lost to display before a forced slot)
    localparam int MAX_WAIT_DEF = 8;

    // Page-swap controller states
    typedef enum logic [0:0] {
        SWP_IDLE    = 1'b0,
        SWP_PENDING = 1'b1
    } swap_state_t;

endpackage : hub75_pkg
`default_nettype wire

// File: rtl/hub75_rd_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_rd_pipe
//  Brief    : Tracks outstanding display reads through the RAM latency and
//             registers the returned word with a one-cycle valid pulse.
//  Revision : 1.0  initial release
// ============================================================================
module hub75_rd_pipe
    import hub75_pkg::*;
#(
    parameter int DATA_W = FB_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              rd_issue,    // RAM read enabled this cycle
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    // Stage k is high k+1 cycles after the read was issued to the RAM.
    // Stage RD_LAT-1 coincides with valid RAM data; stage RD_LAT is the
    // cycle in which the captured word is presented.
    logic [RD_LAT:0] r_vline;

    // Valid shift line; reset drops every read still in flight
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_vline <= '0;
        end else begin
            r_vline <= {r_vline[RD_LAT-1:0], rd_issue};
        end
    end

    // Capture the RAM word when it is valid; hold otherwise
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (r_vline[RD_LAT-1]) begin
            rdata <= ram_rdata;
        end
    end

    assign rvalid = r_vline[RD_LAT];

endmodule : hub75_rd_pipe
`default_nettype wire

// File: rtl/hub75_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_fb_arbiter
//  Brief    : Single-port framebuffer arbiter between the display fetch path
//             and a host write port, with front/back page double buffering
//             flipped only at frame boundaries.
//  Revision : 1.0  initial release
// ============================================================================
module hub75_fb_arbiter
    import hub75_pkg::*;
#(
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W,
    parameter int MAX_WAIT = MAX_WAIT_DEF,   // 1..255
    parameter int RD_LAT   = 1               // 1..3
) (
    input  logic              sys_clk,
    input  logic              rst,
    // display fetch path (front page)
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    // host write port (back page)
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    // page swap control
    input  logic              swap_req,
    input  logic              frame_end,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              disp_page,
    // framebuffer RAM
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W:0]   ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [7:0] c_max_wait = 8'(MAX_WAIT);

    swap_state_t r_swap_state;
    swap_state_t w_swap_next;
    logic        w_flip;
    logic        w_host_elig;
    logic        w_wait_full;
    logic [7:0]  r_wait_cnt;
    logic        w_rd_issue;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign swap_pending = (r_swap_state == SWP_PENDING);
    assign w_wait_full  = (r_wait_cnt == c_max_wait);

    // Display has priority unless the host has already lost MAX_WAIT slots
    always_comb begin
        w_host_elig = host_req && !swap_pending;
        disp_gnt    = 1'b0;
        host_gnt    = 1'b0;
        if (w_host_elig && w_wait_full) begin
            host_gnt = 1'b1;
        end else if (disp_req) begin
            disp_gnt = 1'b1;
        end else if (w_host_elig) begin
            host_gnt = 1'b1;
        end
    end

    // Count consecutive slots an eligible host has lost to the display
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (host_gnt || !w_host_elig) begin
            r_wait_cnt <= '0;
        end else if (disp_gnt && !w_wait_full) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // RAM command register: the grant of cycle T is on the RAM in T+1
    // ------------------------------------------------------------------
    // Register the winning access; the host always targets the back page
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_en <= disp_gnt || host_gnt;
            ram_we <= host_gnt;
            if (host_gnt) begin
                ram_addr  <= {~disp_page, host_addr};
                ram_wdata <= host_wdata;
            end else if (disp_gnt) begin
                ram_addr  <= {disp_page, disp_addr};
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return path
    // ------------------------------------------------------------------
    assign w_rd_issue = ram_en && !ram_we;

    hub75_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .rd_issue  (w_rd_issue),
        .ram_rdata (ram_rdata),
        .rvalid    (disp_rvalid),
        .rdata     (disp_rdata)
    );

    // ------------------------------------------------------------------
    // Page swap controller
    // ------------------------------------------------------------------
    // Swap state register
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_swap_state <= SWP_IDLE;
        end else begin
            r_swap_state <= w_swap_next;
        end
    end

    // Queue a swap on request; flip only on a frame end seen while queued,
    // so a frame_end coinciding with the request does not flip
    always_comb begin
        w_swap_next = r_swap_state;
        w_flip      = 1'b0;
        case (r_swap_state)
            SWP_IDLE: begin
                if (swap_req) begin
                    w_swap_next = SWP_PENDING;
                end
            end
            SWP_PENDING: begin
                if (frame_end) begin
                    w_flip      = 1'b1;
                    w_swap_next = SWP_IDLE;
                end
            end
            default: begin
                w_swap_next = SWP_IDLE;
            end
        endcase
    end

    // Page index and completion pulse, both updated on the same edge
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            disp_page <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            disp_page <= disp_page ^ w_flip;
            swap_done <= w_flip;
        end
    end

endmodule : hub75_fb_arbiter
`default_nettype wire

// File: tb/tb_hub75_fb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hub75_fb_arbiter
//  Brief    : Directed self-checking bench for hub75_fb_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hub75_fb_arbiter;

    localparam int AW = 13;
    localparam int DW = 24;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          host_req;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          swap_req;
    logic          frame_end;
    logic          swap_pending;
    logic          swap_done;
    logic          disp_page;
    logic          ram_en;
    logic          ram_we;
    logic [AW:0]   ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int errs   = 0;
    int checks = 0;

    hub75_fb_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (8),
        .RD_LAT   (1)
    ) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .disp_req     (disp_req),
        .disp_addr    (disp_addr),
        .disp_gnt     (disp_gnt),
        .disp_rvalid  (disp_rvalid),
        .disp_rdata   (disp_rdata),
        .host_req     (host_req),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .swap_req     (swap_req),
        .frame_end    (frame_end),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .disp_page    (disp_page),
        .ram_en       (ram_en),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    // Unwritten RAM locations read back as a pattern derived from the address
    function automatic logic [DW-1:0] pat(input logic [AW:0] a);
        return {10'h2A5, a};
    endfunction

    // Single-port RAM model, one cycle read latency
    logic [DW-1:0] mem   [0:(1<<(AW+1))-1];
    logic          wr_ok [0:(1<<(AW+1))-1];
    always @(posedge sys_clk) begin
        if (rst) begin
            for (int i = 0; i < (1 << (AW + 1)); i++) wr_ok[i] <= 1'b0;
        end else if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr]   <= ram_wdata;
                wr_ok[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= wr_ok[ram_addr] ? mem[ram_addr] : pat(ram_addr);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        int done_cnt;
        logic prev_h;
        logic exp_h;

        rst = 1'b1;
        disp_req = 0; disp_addr = '0;
        host_req = 0; host_addr = '0; host_wdata = '0;
        swap_req = 0; frame_end = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_ram_en",   32'(ram_en),       32'd0);
        check("rst_rvalid",   32'(disp_rvalid),  32'd0);
        check("rst_page",     32'(disp_page),    32'd0);
        check("rst_pending",  32'(swap_pending), 32'd0);
        check("rst_done",     32'(swap_done),    32'd0);
        check("rst_rdata",    32'(disp_rdata),   32'd0);
        rst = 1'b0;

        // ---- display-only stream of 16 reads ----
        for (int c = 0; c < 20; c++) begin
            step();
            disp_req  = (c < 16);
            disp_addr = 13'(c);
            #1;
            check("t1_dgnt",  32'(disp_gnt), 32'(c < 16));
            check("t1_hgnt",  32'(host_gnt), 32'd0);
            check("t1_ramen", 32'(ram_en),   32'(c >= 1 && c <= 16));
            if (c >= 1 && c <= 16) begin
                check("t1_addr", 32'(ram_addr), 32'({1'b0, 13'(c - 1)}));
                check("t1_we",   32'(ram_we),   32'd0);
            end
            check("t1_rvalid", 32'(disp_rvalid), 32'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18)
                check("t1_rdata", 32'(disp_rdata), 32'(pat({1'b0, 13'(c - 3)})));
        end

        // ---- both requesters busy: 8 display, 1 host ----
        prev_h = 1'b0;
        for (int c = 0; c < 27; c++) begin
            step();
            disp_req   = 1'b1;
            disp_addr  = 13'(100 + c);
            host_req   = 1'b1;
            host_addr  = 13'(c);
            host_wdata = 24'h300000 + 24'(c);
            #1;
            exp_h = ((c % 9) == 8);
            check("t2_hgnt", 32'(host_gnt), 32'(exp_h));
            check("t2_dgnt", 32'(disp_gnt), 32'(!exp_h));
            if (c > 0) begin
                check("t2_we", 32'(ram_we), 32'(prev_h));
                if (prev_h) begin
                    check("t2_waddr", 32'(ram_addr),  32'({1'b1, 13'(c - 1)}));
                    check("t2_wdata", 32'(ram_wdata), 32'(24'h300000 + 24'(c - 1)));
                end
            end
            prev_h = exp_h;
        end
        step();
        disp_req = 0; host_req = 0;
        #1;
        check("t2_last_we",   32'(ram_we),   32'd1);
        check("t2_last_addr", 32'(ram_addr), 32'({1'b1, 13'd26}));
        repeat (4) step();

        // ---- host write, swap, flip, read back ----
        step();
        host_req = 1; host_addr = 13'd5; host_wdata = 24'hABCDEF;
        #1;
        check("t3_hgnt", 32'(host_gnt), 32'd1);
        step();
        host_req = 0;
        #1;
        check("t3_we",    32'(ram_we),    32'd1);
        check("t3_addr",  32'(ram_addr),  32'({1'b1, 13'd5}));
        check("t3_wdata", 32'(ram_wdata), 32'hABCDEF);
        step();
        swap_req = 1; host_req = 1; host_addr = 13'd6; host_wdata = 24'h123456;
        #1;
        check("t3_pend0",     32'(swap_pending), 32'd0);
        check("t3_hgnt_edge", 32'(host_gnt),     32'd1);
        step();
        swap_req = 0;
        #1;
        check("t3_pend1",   32'(swap_pending), 32'd1);
        check("t3_hblock",  32'(host_gnt),     32'd0);
        check("t3_oldpage", 32'(ram_addr),     32'({1'b1, 13'd6}));
        for (int k = 0; k < 8; k++) begin
            step();
            #1;
            check("t3_hblock", 32'(host_gnt), 32'd0);
        end
        step();
        frame_end = 1; host_req = 0;
        #1;
        check("t3_page_pre", 32'(disp_page), 32'd0);
        check("t3_done_pre", 32'(swap_done), 32'd0);
        step();
        frame_end = 0;
        #1;
        check("t3_page", 32'(disp_page),    32'd1);
        check("t3_done", 32'(swap_done),    32'd1);
        check("t3_pend", 32'(swap_pending), 32'd0);
        step();
        disp_req = 1; disp_addr = 13'd5;
        #1;
        check("t3_done_off", 32'(swap_done), 32'd0);
        check("t3_dgnt",     32'(disp_gnt),  32'd1);
        step();
        disp_req = 0;
        #1;
        check("t3_raddr", 32'(ram_addr), 32'({1'b1, 13'd5}));
        step();
        step();
        check("t3_rvalid", 32'(disp_rvalid), 32'd1);
        check("t3_rdata",  32'(disp_rdata),  32'hABCDEF);

        // ---- swap_req and frame_end together in IDLE ----
        step();
        swap_req = 1; frame_end = 1;
        #1;
        check("t4_pend0", 32'(swap_pending), 32'd0);
        step();
        swap_req = 0; frame_end = 0;
        #1;
        check("t4_noflip", 32'(disp_page),    32'd1);
        check("t4_nodone", 32'(swap_done),    32'd0);
        check("t4_pend",   32'(swap_pending), 32'd1);
        repeat (3) step();
        frame_end = 1;
        #1;
        step();
        frame_end = 0;
        #1;
        check("t4_page", 32'(disp_page), 32'd0);
        check("t4_done", 32'(swap_done), 32'd1);

        // ---- repeated swap_req while pending ----
        step();
        swap_req = 1;
        #1;
        step();
        swap_req = 0;
        #1;
        check("t6_pend", 32'(swap_pending), 32'd1);
        step();
        swap_req = 1;
        #1;
        step();
        swap_req = 0;
        #1;
        step();
        frame_end = 1;
        #1;
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            frame_end = 0;
            #1;
            if (swap_done) done_cnt++;
        end
        check("t6_done_cnt", 32'(done_cnt),     32'd1);
        check("t6_page",     32'(disp_page),    32'd1);
        check("t6_pend",     32'(swap_pending), 32'd0);
        step();
        frame_end = 1;
        #1;
        step();
        frame_end = 0;
        #1;
        check("t6_page_idle", 32'(disp_page), 32'd1);
        check("t6_done_idle", 32'(swap_done), 32'd0);

        // ---- reset with two reads in flight ----
        step();
        disp_req = 1; disp_addr = 13'd2;
        #1;
        step();
        disp_addr = 13'd3;
        #1;
        step();
        disp_req = 0;
        #1;
        check("t5_inflight", 32'(ram_en), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_ram_en",  32'(ram_en),       32'd0);
        check("t5_ram_addr",32'(ram_addr),     32'd0);
        check("t5_rvalid",  32'(disp_rvalid),  32'd0);
        check("t5_rdata",   32'(disp_rdata),   32'd0);
        check("t5_page",    32'(disp_page),    32'd0);
        check("t5_pend",    32'(swap_pending), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check("t5_no_rvalid", 32'(disp_rvalid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_hub75_fb_arbiter
`default_nettype wire

// File: doc/hub75_fb_arbiter.md
Name: hub75_fb_arbiter

Overview:
- Owns the single-port framebuffer RAM that feeds the HUB75 panels.
- Shares that RAM between two requesters:
  - the display fetch path, which reads pixel words for the row being shifted out;
  - a host pixel-write port.
- Double-buffers the RAM into a front page (displayed) and a back page (host-written), and swaps them only at frame boundaries.
- Sits between the fetch/shift logic and the framebuffer RAM; the main FSM's end-of-frame pulse drives page swaps.

Parameters:
- ADDR_W, 13, per-page word address width; RAM address width is ADDR_W+1.
- DATA_W, 24, pixel word width (RGB888).
- MAX_WAIT, 8, consecutive cycles a waiting host may lose to display before it is granted one slot; legal range 1..255.
- RD_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata; legal range 1..3.

Ports:
- sys_clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- disp_req  in  1  display read request
- disp_addr  in  ADDR_W  display read word address (front page)
- disp_gnt  out  1  display request accepted this cycle
- disp_rvalid  out  1  disp_rdata valid, one-cycle pulse per granted read
- disp_rdata  out  DATA_W  read data returned to the display path
- host_req  in  1  host write request
- host_addr  in  ADDR_W  host write word address (back page)
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host write accepted this cycle
- swap_req  in  1  host pulse: back page complete, flip at next frame end
- frame_end  in  1  one-cycle pulse from main FSM after the last row is latched
- swap_pending  out  1  a swap is queued; host writes are blocked
- swap_done  out  1  one-cycle pulse: pages have flipped
- disp_page  out  1  page index currently displayed
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W+1  {page, word address}
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data

Behaviour:
- Reset (async, rst=1) clears all outputs, flops, and counters to 0:
  - disp_page=0, swap_pending=0, wait_cnt=0, read pipeline emptied.
  - Any in-flight read is dropped and produces no disp_rvalid.
- Grants are combinational from the requests and registered state. At most one of disp_gnt/host_gnt is high per cycle.
- host_eligible = host_req && !swap_pending.
- Arbitration per cycle:
  - If host_eligible && wait_cnt==MAX_WAIT: host_gnt=1, disp_gnt=0.
  - Else if disp_req: disp_gnt=1.
  - Else if host_eligible: host_gnt=1.
- wait_cnt (8 bit):
  - +1 when host_eligible && disp_gnt;
  - cleared when host_gnt=1 or host_eligible=0;
  - never exceeds MAX_WAIT.
- RAM drive: ram_en/ram_we/ram_addr/ram_wdata are registered, driven in cycle T+1 for a grant in cycle T. When there is no grant, ram_en=0 and ram_we=0.
  - Display read: ram_addr={disp_page, disp_addr}, ram_we=0.
  - Host write: ram_addr={~disp_page, host_addr}, ram_we=1, ram_wdata=host_wdata.
- Read return:
  - ram_rdata is captured RD_LAT cycles after ram_en (cycle T+1+RD_LAT).
  - disp_rdata is registered; disp_rvalid=1 at T+2+RD_LAT (T+3 for RD_LAT=1). Reads return in grant order.
  - A fully pipelined stream is supported: back-to-back display grants give back-to-back rvalid.
  - disp_rdata holds its last value when disp_rvalid=0.
- Swap FSM, states IDLE and PENDING:
  - IDLE: swap_req=1 -> PENDING (swap_pending=1 the next cycle).
  - PENDING: swap_req is ignored. frame_end=1 -> toggle disp_page, go to IDLE. swap_done pulses for one cycle, aligned with the new disp_page value.
  - frame_end in IDLE: no effect.
  - swap_req and frame_end in the same cycle while IDLE: the swap is queued and takes effect at the next frame_end, not the current one.
  - A host write granted in the cycle swap_req rises still completes to the old back page. From the following cycle host_gnt=0 until the swap completes.
  - A display read granted before the flip completes from the old page. Grants from the cycle after the flip use the new disp_page.

Decomposition:
- Package hub75_pkg:
  - FB_ADDR_W and FB_DATA_W constants;
  - swap state enum {SWP_IDLE, SWP_PENDING};
  - MAX_WAIT default.
- Sub-module hub75_rd_pipe: an RD_LAT+1 deep valid shift line plus the rdata capture register, with async reset of the valid bits.
- Arbiter and swap FSM stay in the top of this block.

Test Plan:
- Display only, disp_req held high, addr 0..15, RD_LAT=1 -> 16 grants; ram_addr {0,0..15}; disp_rvalid begins 3 cycles after the first grant and data matches the preloaded RAM in order.
- disp_req and host_req both held high, MAX_WAIT=8 -> repeating pattern of 8 disp_gnt then 1 host_gnt; host writes land at {1,addr}; never both grants high.
- Host alone writes addr 5 = 0xABCDEF, then swap_req, then frame_end 10 cycles later -> host_gnt=0 while pending; disp_page goes 0->1 with a swap_done pulse; a display read of addr 5 then returns 0xABCDEF.
- swap_req and frame_end in the same cycle -> no flip; swap_pending=1; the flip occurs at the next frame_end.
- rst asserted with 2 reads in flight -> all outputs 0 immediately; no disp_rvalid after rst drops; disp_page=0.
- swap_req while already PENDING, then one frame_end -> exactly one flip and one swap_done.
